// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA framebuffer fill master
// Contents: framebuffer geometry, RGB565 pixel type, fill FSM states,
//           fill command struct and the rectangle clipping helper.
package vga_pkg;

    localparam int VGA_WIDTH  = 640;
    localparam int VGA_HEIGHT = 480;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE,
        DONE
    } fill_state_t;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] w;
        logic [9:0] h;
        rgb565_t    color;
    } fill_cmd_t;

    // Exclusive end coordinate clipped to the framebuffer edge; the 11-bit sum
    // cannot overflow for 10-bit start and length.
    function automatic logic [10:0] clip_end(input logic [9:0]  start,
                                             input logic [9:0]  len,
                                             input logic [10:0] limit);
        logic [10:0] sum;
        sum = {1'b0, start} + {1'b0, len};
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - pixel walker over a clipped rectangle
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            latch a new rectangle (x0, y0, w, h) and seed the counters
//   advance         step to the next pixel in raster order
//   x0, y0, w, h    rectangle origin and size, sampled on load
//   empty           rectangle on the inputs has no visible pixels
//   last            current pixel is the final pixel of the loaded rectangle
//   pix_next        linear pixel index the walker will hold after this edge
module fb_rect_walker
    import vga_pkg::*;
#(
    parameter int FB_WIDTH  = VGA_WIDTH,
    parameter int FB_HEIGHT = VGA_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [9:0]  x0,
    input  logic [9:0]  y0,
    input  logic [9:0]  w,
    input  logic [9:0]  h,
    output logic        empty,
    output logic        last,
    output logic [18:0] pix_next
);

    localparam logic [10:0] WIDTH11  = 11'(FB_WIDTH);
    localparam logic [10:0] HEIGHT11 = 11'(FB_HEIGHT);
    localparam logic [18:0] WIDTH19  = 19'(FB_WIDTH);

    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  x_start;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [18:0] row_base;
    logic [18:0] pix;
    logic [18:0] load_row_base;
    logic        x_wrap;

    // Constant multiply happens only once per command, on load.
    assign load_row_base = 19'(y0) * WIDTH19;

    assign empty  = (w == 10'd0) || (h == 10'd0) ||
                    ({1'b0, x0} >= WIDTH11) || ({1'b0, y0} >= HEIGHT11);
    assign x_wrap = (({1'b0, x} + 11'd1) == x_end);
    assign last   = x_wrap && (({1'b0, y} + 11'd1) == y_end);

    // Per-pixel path is incremental: either pix+1 or the next row's start.
    always_comb begin
        pix_next = pix;
        if (load) begin
            pix_next = load_row_base + 19'(x0);
        end else if (advance) begin
            pix_next = x_wrap ? (row_base + WIDTH19 + 19'(x_start)) : (pix + 19'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            x_start  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            row_base <= '0;
            pix      <= '0;
        end else begin
            pix <= pix_next;
            if (load) begin
                x        <= x0;
                y        <= y0;
                x_start  <= x0;
                x_end    <= clip_end(x0, w, WIDTH11);
                y_end    <= clip_end(y0, h, HEIGHT11);
                row_base <= load_row_base;
            end else if (advance) begin
                if (x_wrap) begin
                    x        <= x_start;
                    y        <= y + 10'd1;
                    row_base <= row_base + WIDTH19;
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_fb_fill_master.sv
// rtl/vga_fb_fill_master.sv - bus initiator filling rectangles in the RGB565 framebuffer
// Ports:
//   ahb_clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_x0/y0/w/h/color          rectangle and fill colour
//   busy, done, err              progress, one-cycle completion pulse, sticky bus error
//   bus_addr/wdata/wen/ren       write request to the framebuffer (ren tied low)
//   bus_request_stall, bus_error responder hold and error (error valid on accept)
module vga_fb_fill_master
    import vga_pkg::*;
#(
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter int          FB_WIDTH  = 640,
    parameter int          FB_HEIGHT = 480
) (
    input  logic        ahb_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_y0,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [15:0] cmd_color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wen,
    output logic        bus_ren,
    input  logic        bus_request_stall,
    input  logic        bus_error
);

    fill_state_t state;
    fill_cmd_t   cmd_q;

    logic        accept;
    logic        load;
    logic        advance;
    logic        rect_empty;
    logic        rect_last;
    logic [18:0] pix_next;

    assign bus_ren = 1'b0;

    // bus_wen is only ever high in WRITE, so it alone qualifies a transfer.
    assign accept  = bus_wen && !bus_request_stall;
    assign load    = (state == SETUP);
    assign advance = (state == WRITE) && accept && !bus_error;

    fb_rect_walker #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_walker (
        .clk      (ahb_clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .x0       (cmd_q.x0),
        .y0       (cmd_q.y0),
        .w        (cmd_q.w),
        .h        (cmd_q.h),
        .empty    (rect_empty),
        .last     (rect_last),
        .pix_next (pix_next)
    );

    always_ff @(posedge ahb_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
                        err       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (rect_empty) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bus_wen   <= 1'b1;
                        bus_addr  <= FB_BASE + {11'b0, pix_next, 2'b00};
                        bus_wdata <= {16'h0000, cmd_q.color};
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    // While stalled nothing changes: address and data stay put.
                    if (accept) begin
                        if (bus_error) begin
                            err     <= 1'b1;
                            bus_wen <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else if (rect_last) begin
                            bus_wen <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            bus_addr <= FB_BASE + {11'b0, pix_next, 2'b00};
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    bus_wen   <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
